// File: rtl/mem_bist.sv
// mem_bist: built-in self-test initiator for the 1 KiB byte-addressed mem block.
// Optional first-error log is enabled by defining MEM_BIST_ERRLOG_EN.
module mem_bist #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MODV      = 1097,
  parameter logic [31:0] CONF_DATA = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wrdata,
  input  logic [31:0]       rddata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic              zero_ok,
  output logic              conf_ok
`ifdef MEM_BIST_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        first_err_exp,
  output logic [7:0]        first_err_got,
  output logic              first_err_vld
`endif
);

  localparam int unsigned       ACC_W     = $clog2(MODV + 92);
  localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] LAST_BYTE = '1;

  typedef logic [ACC_W-1:0] acc_t;
  localparam acc_t MODV_A = acc_t'(MODV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ZERO,
    S_CONF,
    S_DONE
  } state_e;

  // Per-lane step 4*M[k]; the accumulator walks one lane in strides of four bytes.
  function automatic acc_t lane_inc(input logic [1:0] k);
    case (k)
      2'd0:    lane_inc = acc_t'(4 * 13);
      2'd1:    lane_inc = acc_t'(4 * 17);
      2'd2:    lane_inc = acc_t'(4 * 23);
      default: lane_inc = acc_t'(4 * 7);
    endcase
  endfunction

  function automatic acc_t lane_init(input logic [1:0] k);
    case (k)
      2'd0:    lane_init = acc_t'((13 * 0) % MODV);
      2'd1:    lane_init = acc_t'((17 * 1) % MODV);
      2'd2:    lane_init = acc_t'((23 * 2) % MODV);
      default: lane_init = acc_t'((7 * 3) % MODV);
    endcase
  endfunction

  function automatic acc_t acc_step(input acc_t a, input acc_t inc);
    acc_t s;
    s = a + inc;
    if (s >= MODV_A) begin
      s = s - MODV_A;
    end
    return s;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic [31:0]         wrdata_q, wrdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic                zero_ok_q, zero_ok_d;
  logic                conf_ok_q, conf_ok_d;
  acc_t                acc_q [4];
  acc_t                acc_d [4];

  logic [1:0]          lane;
  logic [7:0]          exp_byte;
  logic                mismatch;

`ifdef MEM_BIST_ERRLOG_EN
  logic [ADDR_W-1:0]   fe_addr_q, fe_addr_d;
  logic [7:0]          fe_exp_q, fe_exp_d;
  logic [7:0]          fe_got_q, fe_got_d;
  logic                fe_vld_q, fe_vld_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wrdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      zero_ok_q <= 1'b0;
      conf_ok_q <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        acc_q[k] <= '0;
      end
`ifdef MEM_BIST_ERRLOG_EN
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      fe_vld_q  <= 1'b0;
`endif
    end else begin
      addr_q    <= addr_d;
      write_q   <= write_d;
      read_q    <= read_d;
      wrdata_q  <= wrdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      zero_ok_q <= zero_ok_d;
      conf_ok_q <= conf_ok_d;
      for (int unsigned k = 0; k < 4; k++) begin
        acc_q[k] <= acc_d[k];
      end
`ifdef MEM_BIST_ERRLOG_EN
      fe_addr_q <= fe_addr_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
      fe_vld_q  <= fe_vld_d;
`endif
    end
  end

  // Outputs are registered one cycle ahead: each *_d reflects the next cycle's bus state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = 1'b0;
    read_d    = 1'b0;
    wrdata_d  = '0;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    zero_ok_d = zero_ok_q;
    conf_ok_d = conf_ok_q;
    for (int unsigned k = 0; k < 4; k++) begin
      acc_d[k] = acc_q[k];
    end
    lane     = addr_q[1:0];
    exp_byte = acc_q[lane][7:0];
    mismatch = 1'b0;
`ifdef MEM_BIST_ERRLOG_EN
    fe_addr_d = fe_addr_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;
    fe_vld_d  = fe_vld_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WRITE;
          addr_d    = '0;
          write_d   = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          zero_ok_d = 1'b1;
          conf_ok_d = 1'b1;
          for (int unsigned k = 0; k < 4; k++) begin
            acc_d[k] = lane_init(2'(k));
          end
          wrdata_d = {acc_d[3][7:0], acc_d[2][7:0], acc_d[1][7:0], acc_d[0][7:0]};
`ifdef MEM_BIST_ERRLOG_EN
          fe_addr_d = '0;
          fe_exp_d  = '0;
          fe_got_d  = '0;
          fe_vld_d  = 1'b0;
`endif
        end
      end

      S_WRITE: begin
        if (addr_q == LAST_WORD) begin
          state_d = S_READ;
          addr_d  = '0;
          read_d  = 1'b1;
          for (int unsigned k = 0; k < 4; k++) begin
            acc_d[k] = lane_init(2'(k));
          end
        end else begin
          addr_d  = addr_q + ADDR_W'(4);
          write_d = 1'b1;
          for (int unsigned k = 0; k < 4; k++) begin
            acc_d[k] = acc_step(acc_q[k], lane_inc(2'(k)));
          end
          wrdata_d = {acc_d[3][7:0], acc_d[2][7:0], acc_d[1][7:0], acc_d[0][7:0]};
        end
      end

      S_READ: begin
        mismatch    = (rddata[7:0] != exp_byte);
        acc_d[lane] = acc_step(acc_q[lane], lane_inc(lane));
        if (mismatch && (err_q != '1)) begin
          err_d = err_q + 1'b1;
        end
`ifdef MEM_BIST_ERRLOG_EN
        if (mismatch && !fe_vld_q) begin
          fe_addr_d = addr_q;
          fe_exp_d  = exp_byte;
          fe_got_d  = rddata[7:0];
          fe_vld_d  = 1'b1;
        end
`endif
        if (addr_q == LAST_BYTE) begin
          state_d = S_ZERO;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          read_d = 1'b1;
        end
      end

      S_ZERO: begin
        if (rddata != '0) begin
          zero_ok_d = 1'b0;
        end
        if (addr_q == LAST_BYTE) begin
          state_d  = S_CONF;
          addr_d   = '0;
          read_d   = 1'b1;
          write_d  = 1'b1;
          wrdata_d = CONF_DATA;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      S_CONF: begin
        if (rddata != '0) begin
          conf_ok_d = 1'b0;
        end
        if (addr_q == LAST_BYTE) begin
          state_d = S_DONE;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) & zero_ok_q & conf_ok_d;
        end else begin
          addr_d   = addr_q + 1'b1;
          read_d   = 1'b1;
          write_d  = 1'b1;
          wrdata_d = CONF_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign write     = write_q;
  assign read      = read_q;
  assign addr      = addr_q;
  assign wrdata    = wrdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign zero_ok   = zero_ok_q;
  assign conf_ok   = conf_ok_q;
`ifdef MEM_BIST_ERRLOG_EN
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
  assign first_err_vld  = fe_vld_q;
`endif

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: byte-addressed memory model with selectable faults.
module tb_mem_bist;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        write, read, busy, done, pass, zero_ok, conf_ok;
  logic [9:0]  addr;
  logic [31:0] wrdata, rddata;
  logic [10:0] err_count;
  logic [63:0] all_out;
`ifdef MEM_BIST_ERRLOG_EN
  logic [9:0]  first_err_addr;
  logic [7:0]  first_err_exp, first_err_got;
  logic        first_err_vld;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int tick     = 0;
  int t0       = 0;
  int fault    = 0;
  bit chk_pat  = 1'b0;
  int pat_hits = 0;
  int conf_cyc = 0;
  int conf_bad = 0;

  logic [7:0] mem [1024];
  logic [9:0] ra;
  logic [7:0] rb;

  mem_bist #(
    .ADDR_W   (10),
    .MODV     (1097),
    .CONF_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .write    (write),
    .read     (read),
    .addr     (addr),
    .wrdata   (wrdata),
    .rddata   (rddata),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .zero_ok  (zero_ok),
    .conf_ok  (conf_ok)
`ifdef MEM_BIST_ERRLOG_EN
    ,
    .first_err_addr(first_err_addr),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got),
    .first_err_vld (first_err_vld)
`endif
  );

  assign all_out = {4'd0, write, read, addr, wrdata, busy, done, pass, err_count, zero_ok, conf_ok};

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    if (write && !read) begin
      for (int k = 0; k < 4; k++) begin
        mem[addr + 10'(k)] <= wrdata[8*k +: 8];
      end
    end
  end

  // fault: 0 ideal, 1 flip bit 0 of bytes 17/900, 2 nonzero idle data at 300, 3 conflict data
  always_comb begin
    rddata = '0;
    ra     = '0;
    rb     = '0;
    if (read && !write) begin
      for (int k = 0; k < 4; k++) begin
        ra = addr + 10'(k);
        rb = mem[ra];
        if (fault == 1 && (ra == 10'd17 || ra == 10'd900)) rb = rb ^ 8'h01;
        rddata[8*k +: 8] = rb;
      end
    end
    if (fault == 3 && read && write) rddata = 32'h0000_0100;
    if (fault == 2 && !read && addr == 10'd300) rddata = 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (read && write) begin
      conf_cyc++;
      if (wrdata != 32'hFFFF_FFFF) conf_bad++;
    end
    if (chk_pat && read && !write) begin
      if (addr == 10'd85) begin
        check("rd_byte85", 64'(rddata[7:0]), 64'd92);
        pat_hits++;
      end
      if (addr == 10'd88) begin
        check("rd_byte88", 64'(rddata[7:0]), 64'd47);
        pat_hits++;
      end
      if (addr == 10'd88) check("err_mid_read", 64'(err_count), 64'd0);
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = tick;
  endtask

  task automatic wait_done(output int n);
    int guard;
    guard = 0;
    while (!done && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n = tick - t0;
    check("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    int base_c, base_b, base_h;

    #12;
    check("rst_outputs", all_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_outputs", all_out, 64'd0);

    // ideal memory: fill pattern, modulus wrap bytes, clean pass
    fault   = 0;
    chk_pat = 1'b1;
    base_c  = conf_cyc;
    base_b  = conf_bad;
    base_h  = pat_hits;
    start_pulse();
    check("w1_addr", 64'(addr), 64'd0);
    check("w1_data", 64'(wrdata), 64'h152E_1100);
    check("w1_strobe", 64'({write, read, busy, done}), 64'b1010);
    @(posedge clk);
    #1;
    check("w2_addr", 64'(addr), 64'd4);
    check("w2_data", 64'(wrdata), 64'h318A_5534);
    wait_done(n);
    chk_pat = 1'b0;
    check("run_len", 64'(n), 64'd3328);
    check("pass", 64'(pass), 64'd1);
    check("err_count", 64'(err_count), 64'd0);
    check("flags_ok", 64'({zero_ok, conf_ok}), 64'b11);
    check("done_strobe", 64'({write, read, busy}), 64'b000);
    check("pat_hits", 64'(pat_hits - base_h), 64'd2);
    check("conf_cycles", 64'(conf_cyc - base_c), 64'd1024);
    check("conf_wrdata", 64'(conf_bad - base_b), 64'd0);
`ifdef MEM_BIST_ERRLOG_EN
    check("errlog_vld_clean", 64'(first_err_vld), 64'd0);
`endif

    // corrupted bytes 17 and 900
    fault = 1;
    start_pulse();
    wait_done(n);
    check("c_run_len", 64'(n), 64'd3328);
    check("c_err_count", 64'(err_count), 64'd2);
    check("c_pass", 64'(pass), 64'd0);
    check("c_flags", 64'({zero_ok, conf_ok}), 64'b11);
`ifdef MEM_BIST_ERRLOG_EN
    check("c_fe_vld", 64'(first_err_vld), 64'd1);
    check("c_fe_addr", 64'(first_err_addr), 64'd17);
    check("c_fe_exp", 64'(first_err_exp), 64'h21);
    check("c_fe_got", 64'(first_err_got), 64'h20);
`endif

    // nonzero data while idle
    fault = 2;
    start_pulse();
    wait_done(n);
    check("z_err_count", 64'(err_count), 64'd0);
    check("z_flags", 64'({zero_ok, conf_ok}), 64'b01);
    check("z_pass", 64'(pass), 64'd0);

    // nonzero data under read/write conflict
    fault  = 3;
    base_c = conf_cyc;
    base_b = conf_bad;
    start_pulse();
    wait_done(n);
    check("x_flags", 64'({zero_ok, conf_ok}), 64'b10);
    check("x_pass", 64'(pass), 64'd0);
    check("x_conf_cycles", 64'(conf_cyc - base_c), 64'd1024);
    check("x_conf_wrdata", 64'(conf_bad - base_b), 64'd0);

    // start while busy is ignored
    fault = 0;
    start_pulse();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("s_busy", 64'(busy), 64'd1);
    check("s_addr", 64'(addr), 64'd745);
    wait_done(n);
    check("s_run_len", 64'(n), 64'd3328);
    check("s_pass", 64'(pass), 64'd1);

    // asynchronous reset at READ cycle 500
    start_pulse();
    repeat (755) @(posedge clk);
    #2;
    check("r_pre_addr", 64'(addr), 64'd499);
    check("r_pre_read", 64'({write, read}), 64'b01);
    reset = 1'b1;
    #1;
    check("r_async_outputs", all_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("r_idle_outputs", all_out, 64'd0);
    start_pulse();
    wait_done(n);
    check("r_run_len", 64'(n), 64'd3328);
    check("r_pass", 64'(pass), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
